// File: rtl/gcd_pkg.sv
// gcd_pkg: definitions shared by the GCD request sequencer and the GCD engine.
//   GCD_WIDTH   default operand/result width; the engine must use the same value
//   seq_state_t sequencer FSM states
package gcd_pkg;

  localparam int GCD_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/gcd_timeout_counter.sv
// gcd_timeout_counter: cycle counter that bounds how long a request may wait on
// the engine.
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset
//   clear    in  return the count to zero (wins over enable)
//   enable   in  advance the count by one; the count saturates instead of wrapping
//   expired  out the count has reached TIMEOUT_CYC-1
module gcd_timeout_counter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CNT_LAST);

endmodule

// File: rtl/gcd_request_sequencer.sv
// gcd_request_sequencer: initiator side of the GCD engine interface.
// Accepts an operand pair, starts the engine, waits for its result (bounded by a
// timeout) and hands the result downstream. Zero operands are answered locally so
// the engine never sees them.
//   CLK, Reset            clock and synchronous active-high reset
//   in_valid/in_ready     operand handshake, in_a/in_b operands
//   number1/number2       registered operands to the engine, S one-cycle start pulse
//   eng_done/eng_gcd      engine completion and result (only looked at in WAIT)
//   res_valid/res_ready   result handshake; res_gcd, res_a, res_b, res_timeout payload
//   busy                  sequencer is not idle
//   dbg_state             current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// A producer keeps valid and its payload stable until that edge; ready never depends
// on valid. in_ready is high only in IDLE; res_valid is high only in RESP, and the
// result payload does not change while res_valid is high.
module gcd_request_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH       = GCD_WIDTH,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] number1,
  output logic [WIDTH-1:0] number2,
  output logic             S,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_gcd,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_gcd,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic             res_timeout,
  output logic             busy,
  output seq_state_t       dbg_state
);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] number1_q, number1_d;
  logic [WIDTH-1:0] number2_q, number2_d;
  logic [WIDTH-1:0] res_gcd_q, res_gcd_d;
  logic [WIDTH-1:0] res_a_q, res_a_d;
  logic [WIDTH-1:0] res_b_q, res_b_d;
  logic             res_timeout_q, res_timeout_d;

  logic cnt_clear;
  logic cnt_en;
  logic cnt_expired;

  gcd_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (CLK),
    .rst     (Reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d       = state_q;
    number1_d     = number1_q;
    number2_d     = number2_q;
    res_gcd_d     = res_gcd_q;
    res_a_d       = res_a_q;
    res_b_d       = res_b_q;
    res_timeout_d = res_timeout_q;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          number1_d = in_a;
          number2_d = in_b;
          res_a_d   = in_a;
          res_b_d   = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            // gcd(x,0)=x and gcd(0,0)=0, so OR-ing the operands is the answer.
            res_gcd_d     = in_a | in_b;
            res_timeout_d = 1'b0;
            state_d       = RESP;
          end else begin
            state_d = START;
          end
        end
      end

      START: begin
        cnt_clear = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        // done is checked first so a completion on the expiry cycle still counts.
        if (eng_done) begin
          res_gcd_d     = eng_gcd;
          res_timeout_d = 1'b0;
          state_d       = RESP;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            res_gcd_d     = '0;
            res_timeout_d = 1'b1;
            state_d       = RESP;
          end
        end
      end

      RESP: begin
        if (res_ready) begin
          res_timeout_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= IDLE;
      number1_q     <= '0;
      number2_q     <= '0;
      res_gcd_q     <= '0;
      res_a_q       <= '0;
      res_b_q       <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      number1_q     <= number1_d;
      number2_q     <= number2_d;
      res_gcd_q     <= res_gcd_d;
      res_a_q       <= res_a_d;
      res_b_q       <= res_b_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Control outputs decode the registered state, so a reset removes S and
  // res_valid on the very next cycle.
  assign in_ready    = (state_q == IDLE);
  assign S           = (state_q == START);
  assign res_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;
  assign number1     = number1_q;
  assign number2     = number2_q;
  assign res_gcd     = res_gcd_q;
  assign res_a       = res_a_q;
  assign res_b       = res_b_q;
  assign res_timeout = res_timeout_q;

endmodule
